ahb2apb_sync_bridge: RTL and testbench
======================================

AHB2APB_SYNC_BRIDGE -- requirements
Module: ahb2apb_sync_bridge

Interface
REQ-001 SHALL have parameter AHB_ADDR_WIDTH, default 32, meaning address width on both sides (paddr = haddr).
REQ-002 SHALL have parameter AHB_DATA_WIDTH, default 32, meaning data width on both sides.
REQ-003 SHALL have parameter NUM_SLV, default 4, range 1..16, meaning number of APB slaves / psel lines.
REQ-004 SHALL have parameter SLV_ADDR_LSB, default 12, meaning LSB of the slave-index field haddr[SLV_ADDR_LSB +: clog2(NUM_SLV)], with a field width of 1 when NUM_SLV=1.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the APB ACCESS-phase limit when the timeout is compiled in.
REQ-006 Ports SHALL be as follows, clock and reset first:
- ahb_hclk  in  1  single clock for both sides.
- ahb_hrstn  in  1  asynchronous, active-low reset.
- ahb_hsel  in  1  slave select.
- ahb_htrans  in  2  transfer type; bit1=1 means NONSEQ/SEQ.
- ahb_haddr  in  AHB_ADDR_WIDTH  address.
- ahb_hwrite  in  1  1 = write.
- ahb_hwdata  in  AHB_DATA_WIDTH  write data, valid in the data phase.
- ahb_hready  out  1  transfer done / bridge able to accept.
- ahb_hresp  out  1  1 = ERROR.
- ahb_hrdata  out  AHB_DATA_WIDTH  read data.
- apb_psel  out  NUM_SLV  one-hot slave select.
- apb_penable  out  1  ACCESS phase.
- apb_pwrite  out  1  direction.
- apb_paddr  out  AHB_ADDR_WIDTH  address.
- apb_pwdata  out  AHB_DATA_WIDTH  write data.
- apb_pready  in  NUM_SLV  per-slave ready.
- apb_prdata  in  NUM_SLV*AHB_DATA_WIDTH  per-slave read data; slave i occupies slice i.
- apb_pslverr  in  NUM_SLV  per-slave error.

Function
REQ-007 SHALL implement FSM states IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2, with all APB outputs and ahb_hrdata registered.
REQ-008 Acceptance: hsel && htrans[1] while ahb_hready=1 (state IDLE or ERR2) SHALL capture haddr and hwrite, then go to WDATA if hwrite=1, SETUP if hwrite=0, or ERR1 if the decoded index >= NUM_SLV.
REQ-009 An IDLE/BUSY transfer (htrans[1]=0) or hsel=0 SHALL be ignored with ahb_hready=1 and ahb_hresp=0.
REQ-010 WDATA SHALL capture hwdata into apb_pwdata and go to SETUP; pwdata SHALL be unchanged by reads.
REQ-011 SETUP SHALL drive apb_psel[idx]=1, penable=0 and the captured paddr/pwrite, then go to ACCESS.
REQ-012 ACCESS SHALL drive psel[idx]=1 and penable=1 until pready[idx]=1.
- On pready[idx]=1 with pslverr[idx]=0: go to IDLE; for reads, load hrdata from prdata slice idx.
- On pready[idx]=1 with pslverr[idx]=1: go to ERR1; hrdata is not updated.
REQ-013 ahb_hready SHALL be 0 in WDATA, SETUP, ACCESS and ERR1, and 1 in IDLE and ERR2.
REQ-014 ahb_hresp SHALL be 1 in ERR1 and ERR2 (two-cycle AHB error), 0 otherwise; ERR1 SHALL always go to ERR2, and ERR2 SHALL behave as IDLE for acceptance.
REQ-015 psel and penable SHALL be 0 in all states other than SETUP and ACCESS, including on the ACCESS to IDLE/ERR1 edge.
REQ-016 Zero-wait-slave latency SHALL be as follows: read hready low 2 cycles; write hready low 3 cycles. Back-to-back transfers SHALL be accepted in the first hready=1 cycle.
REQ-017 pready/pslverr of unselected slaves SHALL be ignored.

Reset
REQ-018 Asserting ahb_hrstn at any time, including mid-transfer, SHALL immediately force:
- state IDLE;
- ahb_hready=1, ahb_hresp=0, ahb_hrdata=0;
- apb_psel=0, apb_penable=0, apb_pwrite=0, apb_paddr=0, apb_pwdata=0;
- timeout counter=0.
REQ-019 After reset release, the first acceptance SHALL be possible in the first clock edge.

Configuration
REQ-020 With macro AHB2APB_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without pready[idx]. On reaching TIMEOUT_CYCLES it SHALL drop psel/penable and go to ERR1.
REQ-021 Without AHB2APB_TIMEOUT_EN, no counter SHALL exist, and ACCESS SHALL wait indefinitely for pready.

Verification
REQ-022 Write: haddr=0x0000_1004, hwdata=0xDEAD_BEEF, pready[1]=1 -> psel=4'b0010, pwdata=0xDEAD_BEEF, pwrite=1; hready low 3 cycles; hresp=0.
REQ-023 Read: haddr=0x0000_3008, prdata slice 3=0x1234_5678, 2 wait states -> penable high 3 cycles; hrdata=0x1234_5678 with hready=1; hready low 4 cycles.
REQ-024 Slave error: pslverr[2]=1 with pready -> hresp=1/hready=0 one cycle, then hresp=1/hready=1; next transfer accepted in ERR2.
REQ-025 NUM_SLV=3, haddr=0x0000_3000 -> no psel pulse; two-cycle ERROR response.
REQ-026 AHB2APB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and pready held 0 -> after 8 ACCESS cycles psel=0 and ERROR response; without the macro the bridge stays in ACCESS for 100 cycles.
REQ-027 Reset asserted during ACCESS -> all outputs at reset values asynchronously; a clean read is accepted after release.

Source files
------------

// File: rtl/ahb2apb_sync_bridge.sv
// Single-clock AHB-to-APB bridge with address-decoded one-hot PSEL and a two-cycle AHB ERROR response.
// Define AHB2APB_TIMEOUT_EN to abort stalled APB ACCESS phases after TIMEOUT_CYCLES cycles.
module ahb2apb_sync_bridge #(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned NUM_SLV        = 4,
    parameter int unsigned SLV_ADDR_LSB   = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                ahb_hclk,
    input  logic                                ahb_hrstn,
    input  logic                                ahb_hsel,
    input  logic [1:0]                          ahb_htrans,
    input  logic [AHB_ADDR_WIDTH-1:0]           ahb_haddr,
    input  logic                                ahb_hwrite,
    input  logic [AHB_DATA_WIDTH-1:0]           ahb_hwdata,
    output logic                                ahb_hready,
    output logic                                ahb_hresp,
    output logic [AHB_DATA_WIDTH-1:0]           ahb_hrdata,
    output logic [NUM_SLV-1:0]                  apb_psel,
    output logic                                apb_penable,
    output logic                                apb_pwrite,
    output logic [AHB_ADDR_WIDTH-1:0]           apb_paddr,
    output logic [AHB_DATA_WIDTH-1:0]           apb_pwdata,
    input  logic [NUM_SLV-1:0]                  apb_pready,
    input  logic [NUM_SLV*AHB_DATA_WIDTH-1:0]   apb_prdata,
    input  logic [NUM_SLV-1:0]                  apb_pslverr
);

    localparam int unsigned IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned IDXE_W = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [AHB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                      pwrite_q, pwrite_d;
    logic [AHB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [NUM_SLV-1:0]        psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic [AHB_DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic                      hready_q, hready_d;
    logic                      hresp_q, hresp_d;

`ifdef AHB2APB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      unused_c;
    assign unused_c = ahb_htrans[0];
`else
    logic                      unused_c;
    assign unused_c = ahb_htrans[0] ^ (TIMEOUT_CYCLES == 0);
`endif

    logic [IDX_W-1:0]          req_idx_c;
    logic                      req_valid_c;
    logic                      req_oob_c;
    logic                      sel_pready_c;
    logic                      sel_pslverr_c;
    logic [AHB_DATA_WIDTH-1:0] sel_prdata_c;

    assign req_idx_c   = ahb_haddr[SLV_ADDR_LSB +: IDX_W];
    assign req_valid_c = ahb_hsel && ahb_htrans[1];
    assign req_oob_c   = ({1'b0, req_idx_c} >= IDXE_W'(NUM_SLV));

    // Only the slave addressed by the current transfer is observed.
    always_comb begin
        sel_pready_c  = 1'b0;
        sel_pslverr_c = 1'b0;
        sel_prdata_c  = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_pready_c  = apb_pready[i];
                sel_pslverr_c = apb_pslverr[i];
                sel_prdata_c  = apb_prdata[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
            end
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
`ifdef AHB2APB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                if (req_valid_c) begin
                    idx_d    = req_idx_c;
                    paddr_d  = ahb_haddr;
                    pwrite_d = ahb_hwrite;
                    if (req_oob_c) begin
                        state_d = S_ERR1;
                    end else if (ahb_hwrite) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_WDATA: begin
                pwdata_d = ahb_hwdata;
                state_d  = S_SETUP;
            end
            S_SETUP: begin
                state_d = S_ACCESS;
`ifdef AHB2APB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_ACCESS: begin
                if (sel_pready_c) begin
                    if (sel_pslverr_c) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d = S_IDLE;
                        if (!pwrite_q) begin
                            hrdata_d = sel_prdata_c;
                        end
                    end
                end
`ifdef AHB2APB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERR1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        hready_d  = (state_d == S_IDLE) || (state_d == S_ERR2);
        hresp_d   = (state_d == S_ERR1) || (state_d == S_ERR2);
        penable_d = (state_d == S_ACCESS);
        psel_d    = '0;
        if ((state_d == S_SETUP) || (state_d == S_ACCESS)) begin
            for (int unsigned i = 0; i < NUM_SLV; i++) begin
                psel_d[i] = (idx_d == IDX_W'(i));
            end
        end
    end

    always_ff @(posedge ahb_hclk or negedge ahb_hrstn) begin
        if (!ahb_hrstn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            hrdata_q  <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= 1'b0;
`ifdef AHB2APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            hrdata_q  <= hrdata_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
`ifdef AHB2APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign ahb_hready  = hready_q;
    assign ahb_hresp   = hresp_q;
    assign ahb_hrdata  = hrdata_q;
    assign apb_psel    = psel_q;
    assign apb_penable = penable_q;
    assign apb_pwrite  = pwrite_q;
    assign apb_paddr   = paddr_q;
    assign apb_pwdata  = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_sync_bridge.sv
// Directed bench for ahb2apb_sync_bridge: a 4-slave instance (TIMEOUT_CYCLES=8) and a 3-slave instance.
module tb_ahb2apb_sync_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    // 4-slave instance
    logic        hsel, hwrite;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata;
    logic        hready, hresp;
    logic [31:0] hrdata;
    logic [3:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pready, pslverr;
    logic [127:0] prdata;

    // 3-slave instance
    logic        hsel3, hwrite3;
    logic [1:0]  htrans3;
    logic [31:0] haddr3;
    logic        hready3, hresp3;
    logic [31:0] hrdata3;
    logic [2:0]  psel3;
    logic        penable3, pwrite3;
    logic [31:0] paddr3, pwdata3;
    logic [2:0]  pready3;
    logic [95:0] prdata3;

    int n_checks = 0;
    int n_errors = 0;

    int wait_states = 0;
    logic err_en = 1'b0, noise = 1'b0, hold_low = 1'b0;
    int acc_cnt = 0;

    int r_low, r_en, r_errlow;
    logic [3:0]  r_psel;
    logic [31:0] r_paddr, r_pwdata;
    logic        r_pwrite;

    always #5 clk = ~clk;

    ahb2apb_sync_bridge #(
        .AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .NUM_SLV(4),
        .SLV_ADDR_LSB(12), .TIMEOUT_CYCLES(8)
    ) u_dut (
        .ahb_hclk(clk), .ahb_hrstn(rst_n), .ahb_hsel(hsel), .ahb_htrans(htrans),
        .ahb_haddr(haddr), .ahb_hwrite(hwrite), .ahb_hwdata(hwdata),
        .ahb_hready(hready), .ahb_hresp(hresp), .ahb_hrdata(hrdata),
        .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
        .apb_paddr(paddr), .apb_pwdata(pwdata), .apb_pready(pready),
        .apb_prdata(prdata), .apb_pslverr(pslverr)
    );

    ahb2apb_sync_bridge #(
        .AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .NUM_SLV(3),
        .SLV_ADDR_LSB(12), .TIMEOUT_CYCLES(8)
    ) u_dut3 (
        .ahb_hclk(clk), .ahb_hrstn(rst_n), .ahb_hsel(hsel3), .ahb_htrans(htrans3),
        .ahb_haddr(haddr3), .ahb_hwrite(hwrite3), .ahb_hwdata(32'h0),
        .ahb_hready(hready3), .ahb_hresp(hresp3), .ahb_hrdata(hrdata3),
        .apb_psel(psel3), .apb_penable(penable3), .apb_pwrite(pwrite3),
        .apb_paddr(paddr3), .apb_pwdata(pwdata3), .apb_pready(pready3),
        .apb_prdata(prdata3), .apb_pslverr(3'b000)
    );

    assign prdata  = {32'h1234_5678, 32'hC2C2_0003, 32'hB1B1_0002, 32'hA0A0_0001};
    assign prdata3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    assign pready3 = penable3 ? psel3 : 3'b000;

    // APB slave model: selected slave answers after wait_states ACCESS cycles; noise drives unselected slaves.
    always @(posedge clk) acc_cnt <= penable ? acc_cnt + 1 : 0;

    always_comb begin
        pready  = '0;
        pslverr = '0;
        if (penable && !hold_low && (acc_cnt >= wait_states)) pready = psel;
        if (err_en) pslverr = psel;
        if (noise) begin
            pready  = pready | ~psel;
            pslverr = pslverr | ~psel;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One AHB transfer on the 4-slave instance; records what the APB side and hready did until hready returns.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr;
        tick();
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hwdata = wdata;
        r_low = 0; r_en = 0; r_errlow = 0;
        r_psel = '0; r_paddr = '0; r_pwdata = '0; r_pwrite = 1'b0;
        while (!hready && r_low < 200) begin
            r_low++;
            if (hresp) r_errlow++;
            if (psel != 4'b0000) begin
                r_psel = psel; r_paddr = paddr; r_pwdata = pwdata; r_pwrite = pwrite;
            end
            if (penable) r_en++;
            tick();
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_hready"},  64'(hready),  64'd1);
        chk({pfx, "_hresp"},   64'(hresp),   64'd0);
        chk({pfx, "_hrdata"},  64'(hrdata),  64'd0);
        chk({pfx, "_psel"},    64'(psel),    64'd0);
        chk({pfx, "_penable"}, 64'(penable), 64'd0);
        chk({pfx, "_pwrite"},  64'(pwrite),  64'd0);
        chk({pfx, "_paddr"},   64'(paddr),   64'd0);
        chk({pfx, "_pwdata"},  64'(pwdata),  64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        hsel = 0; htrans = 0; haddr = 0; hwrite = 0; hwdata = 0;
        hsel3 = 0; htrans3 = 0; haddr3 = 0; hwrite3 = 0;

        #2 rst_n = 1'b0;
        #2 chk_reset_vals("rst");
        tick(); tick();
        #4 rst_n = 1'b1;

        // Write to slave 1, zero wait states
        do_xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF);
        chk("wr_low",    64'(r_low),    64'd3);
        chk("wr_psel",   64'(r_psel),   64'b0010);
        chk("wr_pwrite", 64'(r_pwrite), 64'd1);
        chk("wr_pwdata", 64'(r_pwdata), 64'hDEAD_BEEF);
        chk("wr_paddr",  64'(r_paddr),  64'h1004);
        chk("wr_en",     64'(r_en),     64'd1);
        chk("wr_hresp",  64'(hresp),    64'd0);
        chk("wr_errlow", 64'(r_errlow), 64'd0);
        chk("wr_psel_after",    64'(psel),    64'd0);
        chk("wr_penable_after", 64'(penable), 64'd0);

        // Read slave 3 with 2 wait states while unselected slaves shout ready/error
        wait_states = 2; noise = 1'b1;
        do_xfer(32'h0000_3008, 1'b0, 32'hAAAA_5555);
        chk("rd_low",    64'(r_low),    64'd4);
        chk("rd_en",     64'(r_en),     64'd3);
        chk("rd_psel",   64'(r_psel),   64'b1000);
        chk("rd_pwrite", 64'(r_pwrite), 64'd0);
        chk("rd_hrdata", 64'(hrdata),   64'h1234_5678);
        chk("rd_hresp",  64'(hresp),    64'd0);
        chk("rd_pwdata_kept", 64'(pwdata), 64'hDEAD_BEEF);

        // Slave error on slave 2, then a read accepted straight out of ERR2
        wait_states = 0; noise = 1'b0; err_en = 1'b1;
        do_xfer(32'h0000_2000, 1'b0, 32'h0);
        chk("se_low",    64'(r_low),    64'd3);
        chk("se_errlow", 64'(r_errlow), 64'd1);
        chk("se_psel",   64'(r_psel),   64'b0100);
        chk("se_hresp2", 64'(hresp),    64'd1);
        chk("se_hrdata_kept", 64'(hrdata), 64'h1234_5678);
        err_en = 1'b0;
        do_xfer(32'h0000_0010, 1'b0, 32'h0);
        chk("err2_acc_low",    64'(r_low),  64'd2);
        chk("err2_acc_hresp",  64'(hresp),  64'd0);
        chk("err2_acc_hrdata", 64'(hrdata), 64'hA0A0_0001);
        chk("err2_acc_psel",   64'(r_psel), 64'b0001);

        // Back-to-back write right after the read
        do_xfer(32'h0000_1FFC, 1'b1, 32'h0BAD_F00D);
        chk("b2b_low",    64'(r_low),    64'd3);
        chk("b2b_pwdata", 64'(r_pwdata), 64'h0BAD_F00D);
        chk("b2b_psel",   64'(r_psel),   64'b0010);

        // 3-slave instance: index 3 is out of range, index 2 is valid
        hsel3 = 1; htrans3 = 2'b10; haddr3 = 32'h0000_3000; hwrite3 = 0;
        tick();
        hsel3 = 0; htrans3 = 0; haddr3 = 0;
        chk("oob_e1_hready", 64'(hready3), 64'd0);
        chk("oob_e1_hresp",  64'(hresp3),  64'd1);
        chk("oob_e1_psel",   64'(psel3),   64'd0);
        tick();
        chk("oob_e2_hready", 64'(hready3), 64'd1);
        chk("oob_e2_hresp",  64'(hresp3),  64'd1);
        chk("oob_e2_psel",   64'(psel3),   64'd0);
        tick();
        chk("oob_idle_hresp", 64'(hresp3), 64'd0);
        hsel3 = 1; htrans3 = 2'b10; haddr3 = 32'h0000_2004;
        tick();
        hsel3 = 0; htrans3 = 0; haddr3 = 0;
        chk("s3_setup_psel", 64'(psel3), 64'b100);
        tick(); tick();
        chk("s3_hready", 64'(hready3), 64'd1);
        chk("s3_hrdata", 64'(hrdata3), 64'h3333_0002);

        // Asynchronous reset in the middle of ACCESS
        hold_low = 1'b1;
        hsel = 1; htrans = 2'b10; haddr = 32'h0000_1000; hwrite = 0;
        tick();
        hsel = 0; htrans = 0; haddr = 0;
        tick(); tick();
        chk("mid_penable", 64'(penable), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        hold_low = 1'b0;
        #3 rst_n = 1'b1;
        do_xfer(32'h0000_0004, 1'b0, 32'h0);
        chk("post_rst_low",    64'(r_low),  64'd2);
        chk("post_rst_hrdata", 64'(hrdata), 64'hA0A0_0001);

        // Slave that never answers
        hold_low = 1'b1;
`ifdef AHB2APB_TIMEOUT_EN
        do_xfer(32'h0000_1000, 1'b0, 32'h0);
        chk("tmo_low",    64'(r_low),    64'd10);
        chk("tmo_en",     64'(r_en),     64'd8);
        chk("tmo_errlow", 64'(r_errlow), 64'd1);
        chk("tmo_hresp",  64'(hresp),    64'd1);
        chk("tmo_psel",   64'(psel),     64'd0);
        hold_low = 1'b0;
`else
        hsel = 1; htrans = 2'b10; haddr = 32'h0000_1000; hwrite = 0;
        tick();
        hsel = 0; htrans = 0; haddr = 0;
        repeat (100) tick();
        chk("hang_penable", 64'(penable), 64'd1);
        chk("hang_psel",    64'(psel),    64'b0010);
        chk("hang_hready",  64'(hready),  64'd0);
        #2 rst_n = 1'b0;
        hold_low = 1'b0;
        #3 rst_n = 1'b1;
`endif
        do_xfer(32'h0000_3000, 1'b0, 32'h0);
        chk("final_low",    64'(r_low),  64'd2);
        chk("final_hrdata", 64'(hrdata), 64'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
